// File: rtl/ex_mem_pkg.sv
// Shared widths, M-field bit positions and default-width payload layout for the EX->MEM stage.
package ex_mem_pkg;

    localparam int unsigned DATA_W_D = 32;
    localparam int unsigned REG_W_D  = 5;
    localparam int unsigned WB_W_D   = 2;
    localparam int unsigned CNT_W_D  = 16;
    localparam int unsigned M_W      = 3;

    localparam int unsigned M_BRANCH = 2;
    localparam int unsigned M_RD     = 1;
    localparam int unsigned M_WR     = 0;

    typedef struct packed {
        logic [WB_W_D-1:0]   wb;
        logic [M_W-1:0]      m;
        logic [DATA_W_D-1:0] branch_target;
        logic                zero;
        logic [DATA_W_D-1:0] alu_result;
        logic [DATA_W_D-1:0] reg_data2;
        logic [REG_W_D-1:0]  dest;
    } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_skid_slot.sv
// One-entry payload+valid holding register with load and clear (clear wins).
// Only present when EX_MEM_SKID_EN is defined.
`ifdef EX_MEM_SKID_EN
import ex_mem_pkg::*;

module ex_mem_skid_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`endif

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake, flush, control gating and bubble counter.
// Define EX_MEM_SKID_EN to add a 1-entry skid buffer and make in_ready a register.
import ex_mem_pkg::*;

module ex_mem_pipe_stage #(
    parameter int unsigned DATA_W = DATA_W_D,
    parameter int unsigned REG_W  = REG_W_D,
    parameter int unsigned WB_W   = WB_W_D,
    parameter int unsigned CNT_W  = CNT_W_D
) (
    input  logic              clk,
    input  logic              startin_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   in_wb,
    input  logic [M_W-1:0]    in_m,
    input  logic [DATA_W-1:0] in_branch_target,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_reg_data2,
    input  logic [REG_W-1:0]  in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   out_wb,
    output logic              out_branch,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [DATA_W-1:0] out_branch_target,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_reg_data2,
    output logic [REG_W-1:0]  out_dest,
    output logic [CNT_W-1:0]  bubble_count
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [DATA_W-1:0] branch_target;
        logic              zero;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] reg_data2;
        logic [REG_W-1:0]  dest;
    } pl_t;

    localparam int unsigned PL_W = $bits(pl_t);

    pl_t              w_in_pl;
    pl_t              w_out_pl_nxt;
    pl_t              r_out_pl;
    logic             w_out_valid_nxt;
    logic             r_out_valid;
    logic             w_accept;
    logic [CNT_W-1:0] r_bubble;

    assign w_in_pl = '{wb: in_wb, m: in_m, branch_target: in_branch_target, zero: in_zero,
                       alu_result: in_alu_result, reg_data2: in_reg_data2, dest: in_dest};

`ifdef EX_MEM_SKID_EN
    logic            r_in_ready;
    logic            w_skid_valid;
    logic            w_skid_valid_nxt;
    logic            w_skid_load;
    logic            w_skid_clear;
    logic [PL_W-1:0] w_skid_data;
    pl_t             w_skid_pl;

    ex_mem_skid_slot #(.W(PL_W)) u_skid (
        .clk     (clk),
        .rst_n   (startin_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_pl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    assign w_skid_pl = w_skid_data;
    assign in_ready  = r_in_ready;
    assign w_accept  = in_valid & r_in_ready;

    // Skid drains ahead of new input; a beat arriving under stall parks in the skid.
    always_comb begin
        w_out_valid_nxt = r_out_valid;
        w_out_pl_nxt    = r_out_pl;
        w_skid_load     = 1'b0;
        w_skid_clear    = 1'b0;
        if (flush) begin
            w_out_valid_nxt = 1'b0;
            w_skid_clear    = 1'b1;
        end else if (!r_out_valid || out_ready) begin
            if (w_skid_valid) begin
                w_out_valid_nxt = 1'b1;
                w_out_pl_nxt    = w_skid_pl;
                w_skid_load     = w_accept;
                w_skid_clear    = ~w_accept;
            end else begin
                w_out_valid_nxt = w_accept;
                if (w_accept) w_out_pl_nxt = w_in_pl;
            end
        end else begin
            w_skid_load = w_accept;
        end
    end

    assign w_skid_valid_nxt = ~w_skid_clear & (w_skid_valid | w_skid_load);

    always_ff @(posedge clk or negedge startin_n) begin
        if (!startin_n) r_in_ready <= 1'b0;
        else            r_in_ready <= ~w_skid_valid_nxt;
    end
`else
    logic r_rdy_en;

    // r_rdy_en keeps in_ready low until the first edge after reset release.
    assign in_ready = r_rdy_en & (~r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_out_valid_nxt = r_out_valid;
        w_out_pl_nxt    = r_out_pl;
        if (flush) begin
            w_out_valid_nxt = 1'b0;
        end else if (!r_out_valid || out_ready) begin
            w_out_valid_nxt = w_accept;
            if (w_accept) w_out_pl_nxt = w_in_pl;
        end
    end

    always_ff @(posedge clk or negedge startin_n) begin
        if (!startin_n) r_rdy_en <= 1'b0;
        else            r_rdy_en <= 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge startin_n) begin
        if (!startin_n) begin
            r_out_valid <= 1'b0;
            r_out_pl    <= '0;
            r_bubble    <= '0;
        end else begin
            r_out_valid <= w_out_valid_nxt;
            r_out_pl    <= w_out_pl_nxt;
            if (!r_out_valid && (r_bubble != '1)) r_bubble <= r_bubble + CNT_W'(1);
        end
    end

    // Control is gated by valid so a bubble never writes memory or the register file.
    assign out_valid         = r_out_valid;
    assign out_wb            = r_out_pl.wb & {WB_W{r_out_valid}};
    assign out_branch        = r_out_pl.m[M_BRANCH] & r_out_valid;
    assign out_mem_read      = r_out_pl.m[M_RD] & r_out_valid;
    assign out_mem_write     = r_out_pl.m[M_WR] & r_out_valid;
    assign out_branch_target = r_out_pl.branch_target;
    assign out_zero          = r_out_pl.zero;
    assign out_alu_result    = r_out_pl.alu_result;
    assign out_reg_data2     = r_out_pl.reg_data2;
    assign out_dest          = r_out_pl.dest;
    assign bubble_count      = r_bubble;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Scoreboard bench for ex_mem_pipe_stage: default-width DUT plus a CNT_W=2 copy on the same inputs.
module tb_ex_mem_pipe_stage;
    import ex_mem_pkg::*;

    logic        clk = 1'b0;
    logic        startin_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  in_wb = '0;
    logic [2:0]  in_m = '0;
    logic [31:0] in_branch_target = '0;
    logic        in_zero = 1'b0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_reg_data2 = '0;
    logic [4:0]  in_dest = '0;

    logic        in_ready, out_valid, out_branch, out_mem_read, out_mem_write, out_zero;
    logic [1:0]  out_wb;
    logic [31:0] out_branch_target, out_alu_result, out_reg_data2;
    logic [4:0]  out_dest;
    logic [15:0] bubble_count;

    logic        s_in_ready, s_out_valid, s_out_branch, s_out_mem_read, s_out_mem_write, s_out_zero;
    logic [1:0]  s_out_wb;
    logic [31:0] s_out_branch_target, s_out_alu_result, s_out_reg_data2;
    logic [4:0]  s_out_dest;
    logic [1:0]  s_bubble;

    ex_mem_pipe_stage u_dut (
        .clk(clk), .startin_n(startin_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_wb(in_wb), .in_m(in_m), .in_branch_target(in_branch_target), .in_zero(in_zero),
        .in_alu_result(in_alu_result), .in_reg_data2(in_reg_data2), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready), .out_wb(out_wb), .out_branch(out_branch),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_branch_target(out_branch_target), .out_zero(out_zero), .out_alu_result(out_alu_result),
        .out_reg_data2(out_reg_data2), .out_dest(out_dest), .bubble_count(bubble_count)
    );

    ex_mem_pipe_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .startin_n(startin_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_wb(in_wb), .in_m(in_m), .in_branch_target(in_branch_target), .in_zero(in_zero),
        .in_alu_result(in_alu_result), .in_reg_data2(in_reg_data2), .in_dest(in_dest),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_wb(s_out_wb), .out_branch(s_out_branch),
        .out_mem_read(s_out_mem_read), .out_mem_write(s_out_mem_write),
        .out_branch_target(s_out_branch_target), .out_zero(s_out_zero),
        .out_alu_result(s_out_alu_result), .out_reg_data2(s_out_reg_data2), .out_dest(s_out_dest),
        .bubble_count(s_bubble)
    );

    always #5 clk = ~clk;

    ex_mem_payload_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected MEM view of a beat: controls decoded from m as {branch, mem_read, mem_write}.
    function automatic logic [127:0] exp_view(input ex_mem_payload_t p);
        return 128'({1'b1, p.wb, p.m[2], p.m[1], p.m[0], p.branch_target, p.zero,
                     p.alu_result, p.reg_data2, p.dest});
    endfunction

    function automatic logic [127:0] dut_view();
        return 128'({out_valid, out_wb, out_branch, out_mem_read, out_mem_write, out_branch_target,
                     out_zero, out_alu_result, out_reg_data2, out_dest});
    endfunction

    function automatic logic [127:0] sat_view();
        return 128'({s_out_valid, s_out_wb, s_out_branch, s_out_mem_read, s_out_mem_write,
                     s_out_branch_target, s_out_zero, s_out_alu_result, s_out_reg_data2, s_out_dest});
    endfunction

    function automatic ex_mem_payload_t cur_in();
        ex_mem_payload_t p;
        p.wb = in_wb; p.m = in_m; p.branch_target = in_branch_target; p.zero = in_zero;
        p.alu_result = in_alu_result; p.reg_data2 = in_reg_data2; p.dest = in_dest;
        return p;
    endfunction

    task automatic rand_payload();
        in_wb = 2'($urandom); in_m = 3'($urandom); in_branch_target = $urandom;
        in_zero = 1'($urandom); in_alu_result = $urandom; in_reg_data2 = $urandom;
        in_dest = 5'($urandom);
    endtask

    // One clock: note handshake before the edge, update the reference queue after it.
    task automatic cycle(output logic acc);
        logic fl;
        ex_mem_payload_t p;
        @(negedge clk);
        acc = in_valid & in_ready;
        fl  = flush;
        p   = cur_in();
        @(posedge clk);
        #1;
        if (fl)       exp_q.delete();
        else if (acc) exp_q.push_back(p);
    endtask

    // Monitor: every consumed beat must be the oldest outstanding accepted beat.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_beat: got alu %0h, expected no beat", out_alu_result);
            end else begin
                chk("beat", dut_view(), exp_view(exp_q[0]));
                chk("beat_sat", sat_view(), exp_view(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        if (!out_valid)
            chk("bubble_gate", 128'({out_wb, out_branch, out_mem_read, out_mem_write}), 128'(0));
    end

    initial begin
        logic acc;
        int   n_bb;

        // Reset held with live input
        in_valid = 1'b1; out_ready = 1'b1; rand_payload();
        cycle(acc); cycle(acc);
        chk("rst_out", dut_view(), 128'(0));
        chk("rst_bubble", 128'(bubble_count), 128'(0));
        chk("rst_ready", 128'({in_ready, s_in_ready}), 128'(0));
        in_valid = 1'b0;
        #2 startin_n = 1'b1;
        cycle(acc);
        chk("rel_ready", 128'({in_ready, s_in_ready}), 128'(2'b11));
        chk("rel_bubble", 128'(bubble_count), 128'(1));

        // Streaming, latency 1
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; rand_payload(); in_m = 3'b001; in_alu_result = 32'h10 + 32'(i);
            cycle(acc);
            chk("t2_acc", 128'(acc), 128'(1));
            chk("t2_lat", 128'({out_valid, out_alu_result}), 128'({1'b1, 32'h10 + 32'(i)}));
        end
        chk("t2_ctrl", 128'({out_branch, out_mem_read, out_mem_write}), 128'(3'b001));
        in_valid = 1'b0;
        cycle(acc);

        // Stall with 0xAA held and 0xBB offered
        out_ready = 1'b0;
        in_valid = 1'b1; rand_payload(); in_alu_result = 32'hAA;
        cycle(acc);
        chk("t3_acc_aa", 128'(acc), 128'(1));
        rand_payload(); in_alu_result = 32'hBB;
        n_bb = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(acc);
            if (acc) begin n_bb++; in_valid = 1'b0; end
            chk("t3_hold", 128'({out_valid, out_alu_result}), 128'({1'b1, 32'hAA}));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(acc);
            if (acc) begin n_bb++; in_valid = 1'b0; end
        end
        chk("t3_bb_once", 128'(n_bb), 128'(1));
        chk("t3_drained", 128'(exp_q.size()), 128'(0));

        // Flush with the stage full
        out_ready = 1'b0; in_valid = 1'b1; rand_payload(); in_m = 3'b011;
        cycle(acc); cycle(acc);
        flush = 1'b1;
        cycle(acc);
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_flush", 128'({out_valid, out_mem_read, out_mem_write}), 128'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle(acc);

        // Async reset mid-cycle during a stall
        out_ready = 1'b0; in_valid = 1'b1; rand_payload();
        cycle(acc);
        in_valid = 1'b0;
        cycle(acc);
        chk("t6_pre", 128'(out_valid), 128'(1));
        #2 startin_n = 1'b0;
        #1;
        chk("t6_async", 128'({out_valid, s_out_valid}), 128'(0));
        exp_q.delete();
        cycle(acc); cycle(acc);
        #2 startin_n = 1'b1;

        // Idle bubble counting and saturation
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cycle(acc);
            if (i == 4) chk("t5_sat4", 128'(s_bubble), 128'(3));
            if (i == 5) chk("t5_idle5", 128'(bubble_count), 128'(5));
        end
        chk("t5_idle6", 128'(bubble_count), 128'(6));
        chk("t5_sat6", 128'(s_bubble), 128'(3));

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rand_payload();
            cycle(acc);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle(acc);
        chk("final_drain", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
